key_loader: RTL and testbench
=============================

KEY_LOADER -- requirements
Module: key_loader

Interface
REQ-001 Parameter KEY_WIDTH, default 3, number of key bits driven into the locked netlist key inputs.
REQ-002 Parameter CNT_W, default $clog2(KEY_WIDTH+1), bit-counter width; not overridden by users.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a key load.
REQ-006 clear  input  1  zeroize key and abort any load.
REQ-007 key_bit_valid  input  1  serial key source has a bit.
REQ-008 key_bit  input  1  serial key data, LSB first.
REQ-009 key_bit_ready  output  1  loader accepts key_bit this cycle.
REQ-010 key_out  output  KEY_WIDTH  parallel key to locked circuit; key_out[i] drives key input i.
REQ-011 key_valid  output  1  key_out holds a complete, accepted key.
REQ-012 busy  output  1  load in progress.
REQ-013 error  output  1  last load rejected (parity build only; tied 0 otherwise).

Function
REQ-014 FSM states IDLE, SHIFT, CHECK, LOADED, ERROR; encoding is a package enum.
REQ-015 IDLE/LOADED/ERROR + start=1 (clear=0) -> SHIFT; shadow register and bit counter cleared; key_out, key_valid unchanged until load completes or clear.
REQ-016 SHIFT: key_bit_ready=1; a bit transfers only when key_bit_valid && key_bit_ready; bit n (n=0 first) written to shadow[n]; counter increments per transfer.
REQ-017 key_bit_valid=0 in SHIFT: hold, no timeout.
REQ-018 Transfer of bit KEY_WIDTH-1 (build without parity) -> LOADED next edge; same edge loads key_out <= shadow with final bit, key_valid=1.
REQ-019 Latency: key_valid rises on the edge that accepts the last data bit (output registered, visible next cycle).
REQ-020 busy=1 in SHIFT and CHECK only; key_bit_ready=1 in SHIFT only.
REQ-021 start while busy: ignored.
REQ-022 clear=1 in any state: next edge -> IDLE, key_out=0, key_valid=0, error=0, shadow=0, counter=0; clear wins over start and over a simultaneous bit transfer.
REQ-023 LOADED: key_out stable until clear or a new load completes successfully; a new load drops key_valid to 0 at start acceptance.
REQ-024 Counter never wraps: compared against KEY_WIDTH (or KEY_WIDTH+1 with parity); KEY_WIDTH=1 supported.

Reset
REQ-025 rst_n=0 asynchronously forces IDLE, key_out=0, key_valid=0, busy=0, key_bit_ready=0, error=0, shadow=0, counter=0.
REQ-026 Reset deassertion mid-stream: partial bits discarded, no output glitch to non-zero key.

Configuration
REQ-027 Macro KEY_LOADER_PARITY_EN.
REQ-028 Defined: after KEY_WIDTH data bits, one extra parity bit accepted in SHIFT; then CHECK for one cycle; even parity over data+parity bit -> LOADED (key_out updated, key_valid=1, error=0); mismatch -> ERROR (key_out=0, key_valid=0, error=1).
REQ-029 Defined: ERROR exits only on start (error cleared at acceptance) or clear.
REQ-030 Undefined: no parity bit, CHECK and ERROR unreachable, error tied 0, behaviour per REQ-018.

Structure
REQ-031 Package key_loader_pkg: state enum, DEFAULT_KEY_WIDTH=3 constant.
REQ-032 Sub-module key_shift_reg (shadow register + counter, KEY_WIDTH parameter, load/clear/shift_en ports); FSM and output registers in key_loader.

Verification
REQ-033 Reset then start, stream 1,0,1 with valid continuous -> key_out=3'b101, key_valid=1 one cycle after third bit accepted, busy=0.
REQ-034 Stream 0,1,1 with key_bit_valid gapped 2 cycles between bits -> no extra transfers, key_out=3'b110.
REQ-035 clear asserted after 2 bits -> next cycle IDLE, key_out=0, key_valid=0; later start+stream 1,1,1 -> key_out=3'b111.
REQ-036 PARITY_EN: bits 1,0,1 + parity 0 -> key_out=3'b101, error=0; bits 1,0,1 + parity 1 -> key_out=0, error=1, key_valid=0.
REQ-037 start pulsed during SHIFT and rst_n pulsed low mid-stream -> start ignored; reset forces all outputs 0 immediately (asynchronously).

Source files
------------

// File: rtl/key_loader_pkg.sv
// Shared types and constants for the serial key loader.
// The parity option is selected with the KEY_LOADER_PARITY_EN macro.
package key_loader_pkg;

  localparam int DEFAULT_KEY_WIDTH = 3;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK,
    LOADED,
    ERROR
  } state_t;

endpackage

// File: rtl/key_shift_reg.sv
// Shadow register and bit counter for the serial key loader.
// With KEY_LOADER_PARITY_EN the bit after the last data bit is kept as the parity bit.
module key_shift_reg
  import key_loader_pkg::*;
#(
  parameter int KEY_WIDTH = DEFAULT_KEY_WIDTH,
  parameter int CNT_W     = $clog2(KEY_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 load,
  input  logic                 shift_en,
  input  logic                 bit_in,
  output logic [KEY_WIDTH-1:0] shadow,
  output logic [KEY_WIDTH-1:0] shadow_next,
  output logic [CNT_W-1:0]     count,
  output logic                 parity_bit
);

  // Shadow contents including the bit being accepted this cycle, so the
  // final data bit can reach key_out on the same edge that accepts it.
  always_comb begin
    shadow_next = shadow;
    for (int i = 0; i < KEY_WIDTH; i++) begin
      if (shift_en && (count == CNT_W'(i))) begin
        shadow_next[i] = bit_in;
      end
    end
  end

  // Counter saturates at KEY_WIDTH; a transfer at that point is the parity bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= '0;
      count      <= '0;
      parity_bit <= 1'b0;
    end else if (clear || load) begin
      shadow     <= '0;
      count      <= '0;
      parity_bit <= 1'b0;
    end else if (shift_en) begin
      if (count < CNT_W'(KEY_WIDTH)) begin
        shadow <= shadow_next;
        count  <= count + CNT_W'(1);
      end else begin
        parity_bit <= bit_in;
      end
    end
  end

endmodule

// File: rtl/key_loader.sv
// Serial-to-parallel key loader for a logic-locked netlist.
// Define KEY_LOADER_PARITY_EN to accept a trailing even-parity bit and
// reject loads whose parity fails; otherwise error is tied low.
module key_loader
  import key_loader_pkg::*;
#(
  parameter int KEY_WIDTH = DEFAULT_KEY_WIDTH,
  parameter int CNT_W     = $clog2(KEY_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 key_bit_valid,
  input  logic                 key_bit,
  output logic                 key_bit_ready,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 busy,
  output logic                 error
);

  state_t               state;
  logic                 transfer;
  logic                 accept_start;
  logic [KEY_WIDTH-1:0] shadow;
  logic [KEY_WIDTH-1:0] shadow_next;
  logic [CNT_W-1:0]     count;
  logic                 parity_bit;

  assign transfer     = key_bit_valid && key_bit_ready;
  assign accept_start = start && !clear &&
                        ((state == IDLE) || (state == LOADED) || (state == ERROR));

`ifdef KEY_LOADER_PARITY_EN
  logic parity_phase;
  logic parity_ok;
  logic [KEY_WIDTH-1:0] unused_shadow_next;

  assign parity_phase       = (count == CNT_W'(KEY_WIDTH));
  assign parity_ok          = ~(^shadow ^ parity_bit);
  assign unused_shadow_next = shadow_next;
`else
  logic last_data;
  logic [KEY_WIDTH:0] unused_shadow_par;

  assign last_data         = (count == CNT_W'(KEY_WIDTH - 1));
  assign unused_shadow_par = {shadow, parity_bit};
  assign error             = 1'b0;
`endif

  key_shift_reg #(
    .KEY_WIDTH(KEY_WIDTH),
    .CNT_W    (CNT_W)
  ) u_shift (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .load       (accept_start),
    .shift_en   (transfer && !clear),
    .bit_in     (key_bit),
    .shadow     (shadow),
    .shadow_next(shadow_next),
    .count      (count),
    .parity_bit (parity_bit)
  );

  // Load sequencing with all outputs registered; clear overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      key_out       <= '0;
      key_valid     <= 1'b0;
      busy          <= 1'b0;
      key_bit_ready <= 1'b0;
`ifdef KEY_LOADER_PARITY_EN
      error         <= 1'b0;
`endif
    end else if (clear) begin
      state         <= IDLE;
      key_out       <= '0;
      key_valid     <= 1'b0;
      busy          <= 1'b0;
      key_bit_ready <= 1'b0;
`ifdef KEY_LOADER_PARITY_EN
      error         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, LOADED, ERROR: begin
          if (start) begin
            state         <= SHIFT;
            busy          <= 1'b1;
            key_bit_ready <= 1'b1;
            key_valid     <= 1'b0;
`ifdef KEY_LOADER_PARITY_EN
            error         <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          if (transfer) begin
`ifdef KEY_LOADER_PARITY_EN
            if (parity_phase) begin
              state         <= CHECK;
              key_bit_ready <= 1'b0;
            end
`else
            if (last_data) begin
              state         <= LOADED;
              key_out       <= shadow_next;
              key_valid     <= 1'b1;
              busy          <= 1'b0;
              key_bit_ready <= 1'b0;
            end
`endif
          end
        end
        CHECK: begin
          busy          <= 1'b0;
          key_bit_ready <= 1'b0;
`ifdef KEY_LOADER_PARITY_EN
          if (parity_ok) begin
            state     <= LOADED;
            key_out   <= shadow;
            key_valid <= 1'b1;
            error     <= 1'b0;
          end else begin
            state     <= ERROR;
            key_out   <= '0;
            key_valid <= 1'b0;
            error     <= 1'b1;
          end
`else
          state <= IDLE;
`endif
        end
        default: begin
          state         <= IDLE;
          busy          <= 1'b0;
          key_bit_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_loader.sv
// Self-checking bench for key_loader with a behavioural model of the loaded key.
// Covers the parity build too when KEY_LOADER_PARITY_EN is defined.
module tb_key_loader;

  localparam int KW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          clear;
  logic          key_bit_valid;
  logic          key_bit;
  logic          key_bit_ready;
  logic [KW-1:0] key_out;
  logic          key_valid;
  logic          busy;
  logic          error;

  int            errors = 0;
  int            checks = 0;

  logic [KW-1:0] model_key;
  logic          model_valid;
  logic          model_err;

  key_loader #(.KEY_WIDTH(KW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .clear        (clear),
    .key_bit_valid(key_bit_valid),
    .key_bit      (key_bit),
    .key_bit_ready(key_bit_ready),
    .key_out      (key_out),
    .key_valid    (key_valid),
    .busy         (busy),
    .error        (error)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int g);
    int n;
    n = (g < 0) ? int'($urandom_range(3, 0)) : g;
    repeat (n) begin
      key_bit_valid = 1'b0;
      key_bit       = 1'($urandom);
      @(posedge clk); #1;
    end
    key_bit_valid = 1'b1;
    key_bit       = b;
    @(posedge clk); #1;
    key_bit_valid = 1'b0;
  endtask

  // Streams data bits from index 'first' upward, then the parity bit in the
  // parity build, and leaves time at the negedge where the result is visible.
  task automatic feed_bits(input logic [KW-1:0] data, input int g, input logic bad, input int first);
    logic p;
    for (int i = first; i < KW; i++) send_bit(data[i], g);
`ifdef KEY_LOADER_PARITY_EN
    p = logic'(($countones(data) + int'(bad)) % 2);
    send_bit(p, g);
    @(posedge clk); #1;
    if ((($countones(data) + int'(p)) % 2) == 0) begin
      model_key = data; model_valid = 1'b1; model_err = 1'b0;
    end else begin
      model_key = '0; model_valid = 1'b0; model_err = 1'b1;
    end
`else
    p = bad;
    model_key = data; model_valid = 1'b1; model_err = 1'b0;
`endif
    @(negedge clk);
  endtask

  task automatic drive_load(input logic [KW-1:0] data, input int g, input logic bad);
    pulse_start();
    model_valid = 1'b0; model_err = 1'b0;
    feed_bits(data, g, bad, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; key_bit_valid = 1'b0; key_bit = 1'b0;
    model_key = '0; model_valid = 1'b0; model_err = 1'b0;
    #12;
    checks++; if (key_out !== 3'b000) begin errors++; $display("[TB] FAIL reset_key: got %b expected 000", key_out); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", key_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (key_bit_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", key_bit_ready); end
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL reset_error: got %b expected 0", error); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_continuous();
    drive_load(3'b101, 0, 1'b0);
    checks++; if (key_out !== model_key) begin errors++; $display("[TB] FAIL cont_key: got %b expected %b", key_out, model_key); end
    checks++; if (key_valid !== 1'b1) begin errors++; $display("[TB] FAIL cont_valid: got %b expected 1", key_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL cont_busy: got %b expected 0", busy); end
    checks++; if (key_bit_ready !== 1'b0) begin errors++; $display("[TB] FAIL cont_ready: got %b expected 0", key_bit_ready); end
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL cont_error: got %b expected 0", error); end
  endtask

  task automatic test_gapped();
    drive_load(3'b110, 2, 1'b0);
    checks++; if (key_out !== 3'b110) begin errors++; $display("[TB] FAIL gap_key: got %b expected 110", key_out); end
    checks++; if (key_valid !== 1'b1) begin errors++; $display("[TB] FAIL gap_valid: got %b expected 1", key_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL gap_busy: got %b expected 0", busy); end
  endtask

  task automatic test_clear();
    pulse_start();
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    clear = 1'b1; start = 1'b1; key_bit_valid = 1'b1; key_bit = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; start = 1'b0; key_bit_valid = 1'b0;
    model_key = '0; model_valid = 1'b0; model_err = 1'b0;
    @(negedge clk);
    checks++; if (key_out !== model_key) begin errors++; $display("[TB] FAIL clear_key: got %b expected %b", key_out, model_key); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL clear_valid: got %b expected 0", key_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL clear_busy: got %b expected 0", busy); end
    checks++; if (key_bit_ready !== 1'b0) begin errors++; $display("[TB] FAIL clear_ready: got %b expected 0", key_bit_ready); end
    drive_load(3'b111, 0, 1'b0);
    checks++; if (key_out !== 3'b111) begin errors++; $display("[TB] FAIL clear_reload_key: got %b expected 111", key_out); end
    checks++; if (key_valid !== 1'b1) begin errors++; $display("[TB] FAIL clear_reload_valid: got %b expected 1", key_valid); end
  endtask

  task automatic test_back_to_back();
    logic [KW-1:0] d;
    drive_load(3'b010, 0, 1'b0);
    d = KW'($urandom);
    pulse_start();
    @(negedge clk);
    checks++; if (key_out !== model_key) begin errors++; $display("[TB] FAIL b2b_hold_key: got %b expected %b", key_out, model_key); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_valid_drop: got %b expected 0", key_valid); end
    checks++; if (key_bit_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready: got %b expected 1", key_bit_ready); end
    model_valid = 1'b0;
    feed_bits(d, 0, 1'b0, 0);
    checks++; if (key_out !== d) begin errors++; $display("[TB] FAIL b2b_key: got %b expected %b", key_out, d); end
  endtask

  task automatic test_start_ignored();
    logic [KW-1:0] d;
    d = 3'b110;
    pulse_start();
    send_bit(d[0], 0);
    pulse_start();
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ign_busy: got %b expected 1", busy); end
    feed_bits(d, 1, 1'b0, 1);
    checks++; if (key_out !== model_key) begin errors++; $display("[TB] FAIL ign_key: got %b expected %b", key_out, model_key); end
    checks++; if (key_valid !== model_valid) begin errors++; $display("[TB] FAIL ign_valid: got %b expected %b", key_valid, model_valid); end
  endtask

  task automatic test_async_reset();
    drive_load(3'b011, 0, 1'b0);
    pulse_start();
    send_bit(1'b1, 0);
    key_bit_valid = 1'b1; key_bit = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_key = '0; model_valid = 1'b0; model_err = 1'b0;
    checks++; if (key_out !== model_key) begin errors++; $display("[TB] FAIL arst_key: got %b expected %b", key_out, model_key); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL arst_busy: got %b expected 0", busy); end
    checks++; if (key_bit_ready !== 1'b0) begin errors++; $display("[TB] FAIL arst_ready: got %b expected 0", key_bit_ready); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL arst_valid: got %b expected 0", key_valid); end
    key_bit_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (key_out !== 3'b000) begin errors++; $display("[TB] FAIL arst_release_key: got %b expected 000", key_out); end
    drive_load(3'b100, 0, 1'b0);
    checks++; if (key_out !== model_key) begin errors++; $display("[TB] FAIL arst_reload_key: got %b expected %b", key_out, model_key); end
  endtask

`ifdef KEY_LOADER_PARITY_EN
  task automatic test_parity();
    drive_load(3'b101, 0, 1'b0);
    checks++; if (key_out !== 3'b101) begin errors++; $display("[TB] FAIL par_good_key: got %b expected 101", key_out); end
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL par_good_error: got %b expected 0", error); end
    drive_load(3'b101, 0, 1'b1);
    checks++; if (key_out !== 3'b000) begin errors++; $display("[TB] FAIL par_bad_key: got %b expected 000", key_out); end
    checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL par_bad_error: got %b expected 1", error); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL par_bad_valid: got %b expected 0", key_valid); end
    pulse_start();
    @(negedge clk);
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL par_restart_error: got %b expected 0", error); end
    feed_bits(3'b011, 0, 1'b0, 0);
    checks++; if (key_out !== 3'b011) begin errors++; $display("[TB] FAIL par_restart_key: got %b expected 011", key_out); end
  endtask
`endif

  task automatic test_random();
    logic [KW-1:0] d;
    logic          bad;
    for (int i = 0; i < 10; i++) begin
      d = KW'($urandom);
`ifdef KEY_LOADER_PARITY_EN
      bad = 1'($urandom);
`else
      bad = 1'b0;
`endif
      drive_load(d, -1, bad);
      checks++; if (key_out !== model_key) begin errors++; $display("[TB] FAIL rand_key[%0d]: got %b expected %b", i, key_out, model_key); end
      checks++; if (key_valid !== model_valid) begin errors++; $display("[TB] FAIL rand_valid[%0d]: got %b expected %b", i, key_valid, model_valid); end
      checks++; if (error !== model_err) begin errors++; $display("[TB] FAIL rand_error[%0d]: got %b expected %b", i, error, model_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rand_busy[%0d]: got %b expected 0", i, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gapped();
    test_clear();
    test_back_to_back();
    test_start_ignored();
    test_async_reset();
`ifdef KEY_LOADER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
